mesi_isc_broad_cntl: RTL and testbench

//  Consumer of the broad FIFO: pops one broadcast request (breq) at a time and

---
 rtl/mesi_isc_pkg.sv | 21 ++
 rtl/mesi_isc_broad_cpu_slot.sv | 45 ++++
 rtl/mesi_isc_broad_cntl.sv | 119 +++++++++++
 tb/tb_mesi_isc_broad_cntl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesi_isc_pkg.sv
// Shared encodings for the ISC: cbus commands, broadcast request
// types and the broadcast-controller state type.
package mesi_isc_pkg;

    localparam logic [2:0] MESI_ISC_CBUS_CMD_NOP      = 3'd0;
    localparam logic [2:0] MESI_ISC_CBUS_CMD_WR_SNOOP = 3'd1;
    localparam logic [2:0] MESI_ISC_CBUS_CMD_RD_SNOOP = 3'd2;
    localparam logic [2:0] MESI_ISC_CBUS_CMD_EN_WR    = 3'd3;
    localparam logic [2:0] MESI_ISC_CBUS_CMD_EN_RD    = 3'd4;

    localparam logic [1:0] MESI_ISC_BREQ_TYPE_NOP = 2'd0;
    localparam logic [1:0] MESI_ISC_BREQ_TYPE_WR  = 2'd1;
    localparam logic [1:0] MESI_ISC_BREQ_TYPE_RD  = 2'd2;

    typedef enum logic [1:0] {
        BROAD_IDLE,
        BROAD_SNOOP,
        BROAD_ENABLE
    } broad_cntl_state_t;

endpackage

// File: rtl/mesi_isc_broad_cpu_slot.sv
// Per-CPU cbus slot: pending-snoop bit and registered command.
// Ports: set_snoop/set_enable load a command, ack retires it, cmd out.
module mesi_isc_broad_cpu_slot
    import mesi_isc_pkg::*;
#(
    parameter int CBUS_CMD_WIDTH   = 3,
    parameter int BROAD_TYPE_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        set_snoop,
    input  logic                        set_enable,
    input  logic                        ack,
    input  logic [BROAD_TYPE_WIDTH-1:0] broad_type,
    output logic                        pending,
    output logic [CBUS_CMD_WIDTH-1:0]   cmd
);

    logic en_q;
    logic is_wr;

    assign is_wr = (broad_type == BROAD_TYPE_WIDTH'(MESI_ISC_BREQ_TYPE_WR));

    // An ack only retires a command this slot is actually showing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
            en_q    <= 1'b0;
            cmd     <= CBUS_CMD_WIDTH'(MESI_ISC_CBUS_CMD_NOP);
        end else if (set_snoop) begin
            pending <= 1'b1;
            cmd     <= is_wr ? CBUS_CMD_WIDTH'(MESI_ISC_CBUS_CMD_WR_SNOOP)
                             : CBUS_CMD_WIDTH'(MESI_ISC_CBUS_CMD_RD_SNOOP);
        end else if (set_enable) begin
            en_q <= 1'b1;
            cmd  <= is_wr ? CBUS_CMD_WIDTH'(MESI_ISC_CBUS_CMD_EN_WR)
                          : CBUS_CMD_WIDTH'(MESI_ISC_CBUS_CMD_EN_RD);
        end else if (ack && (pending || en_q)) begin
            pending <= 1'b0;
            en_q    <= 1'b0;
            cmd     <= CBUS_CMD_WIDTH'(MESI_ISC_CBUS_CMD_NOP);
        end
    end

endmodule

// File: rtl/mesi_isc_broad_cntl.sv
// Broadcast controller: pops breqs, snoops the other CPUs, then enables
// the originator. Ports: broad FIFO head/pop, per-CPU cbus ack/cmd, status.
module mesi_isc_broad_cntl
    import mesi_isc_pkg::*;
#(
    parameter int CBUS_CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        broad_fifo_status_empty_i,
    input  logic [ADDR_WIDTH-1:0]       broad_addr_i,
    input  logic [BROAD_TYPE_WIDTH-1:0] broad_type_i,
    input  logic [1:0]                  broad_cpu_id_i,
    input  logic [BROAD_ID_WIDTH-1:0]   broad_id_i,
    output logic                        broad_fifo_rd_o,
    input  logic [3:0]                  cbus_ack_array_i,
    output logic [4*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o,
    output logic [ADDR_WIDTH-1:0]       cbus_addr_o,
    output logic                        broad_busy_o,
    output logic [BROAD_ID_WIDTH-1:0]   broad_id_active_o
);

    broad_cntl_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [BROAD_TYPE_WIDTH-1:0] type_q;
    logic [1:0]                  cpu_q;
    logic [BROAD_ID_WIDTH-1:0]   id_q;

    logic                        pop;
    logic                        is_req;
    logic [3:0]                  pending;
    logic [3:0]                  pend_left;
    logic [3:0]                  set_snoop;
    logic [3:0]                  set_enable;
    logic [BROAD_TYPE_WIDTH-1:0] slot_type;

    assign is_req =
        (broad_type_i == BROAD_TYPE_WIDTH'(MESI_ISC_BREQ_TYPE_WR)) ||
        (broad_type_i == BROAD_TYPE_WIDTH'(MESI_ISC_BREQ_TYPE_RD));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= BROAD_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        set_snoop  = 4'b0000;
        set_enable = 4'b0000;
        slot_type  = type_q;
        pend_left  = pending & ~cbus_ack_array_i;
        unique case (state_q)
            BROAD_IDLE: begin
                // Snoop command type comes straight off the FIFO head,
                // since the latch only captures it at this same edge.
                slot_type = broad_type_i;
                if (!broad_fifo_status_empty_i) begin
                    pop = 1'b1;
                    if (is_req) begin
                        state_d   = BROAD_SNOOP;
                        set_snoop = 4'b1111 &
                                    ~(4'b0001 << broad_cpu_id_i);
                    end
                end
            end
            BROAD_SNOOP: begin
                if (pend_left == 4'b0000) begin
                    state_d    = BROAD_ENABLE;
                    set_enable = 4'b0001 << cpu_q;
                end
            end
            BROAD_ENABLE: begin
                if (cbus_ack_array_i[cpu_q]) state_d = BROAD_IDLE;
            end
            default: state_d = BROAD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            type_q <= '0;
            cpu_q  <= '0;
            id_q   <= '0;
        end else if (pop) begin
            addr_q <= broad_addr_i;
            type_q <= broad_type_i;
            cpu_q  <= broad_cpu_id_i;
            id_q   <= broad_id_i;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_slot
        mesi_isc_broad_cpu_slot #(
            .CBUS_CMD_WIDTH  (CBUS_CMD_WIDTH),
            .BROAD_TYPE_WIDTH(BROAD_TYPE_WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .set_snoop (set_snoop[i]),
            .set_enable(set_enable[i]),
            .ack       (cbus_ack_array_i[i]),
            .broad_type(slot_type),
            .pending   (pending[i]),
            .cmd       (cbus_cmd_array_o[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH])
        );
    end

    assign broad_fifo_rd_o   = pop;
    assign cbus_addr_o       = addr_q;
    assign broad_id_active_o = id_q;
    assign broad_busy_o      = (state_q != BROAD_IDLE);

endmodule

// File: tb/tb_mesi_isc_broad_cntl.sv
// Bench for mesi_isc_broad_cntl: FIFO model plus directed breqs;
// a negedge monitor checks every output change against a queue.
module tb_mesi_isc_broad_cntl;

    localparam logic [2:0] NOP = 3'd0;
    localparam logic [2:0] WS  = 3'd1;
    localparam logic [2:0] RS  = 3'd2;
    localparam logic [2:0] EW  = 3'd3;
    localparam logic [2:0] ER  = 3'd4;

    localparam logic [1:0] T_NOP = 2'd0;
    localparam logic [1:0] T_WR  = 2'd1;
    localparam logic [1:0] T_RD  = 2'd2;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  typ;
        logic [1:0]  cpu;
        logic [6:0]  id;
    } fent_t;

    typedef struct {
        int          cyc;
        logic        rd;
        logic [11:0] cmd;
        logic        busy;
        logic [31:0] addr;
        logic [6:0]  id;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        broad_fifo_status_empty_i = 1'b1;
    logic [31:0] broad_addr_i = '0;
    logic [1:0]  broad_type_i = '0;
    logic [1:0]  broad_cpu_id_i = '0;
    logic [6:0]  broad_id_i = '0;
    logic        broad_fifo_rd_o;
    logic [3:0]  cbus_ack_array_i = '0;
    logic [11:0] cbus_cmd_array_o;
    logic [31:0] cbus_addr_o;
    logic        broad_busy_o;
    logic [6:0]  broad_id_active_o;

    fent_t fq[$];
    ev_t   exq[$];
    int    cyc = 0;
    int    checks = 0;
    int    passes = 0;
    logic  mon_en = 1'b0;
    logic  rd_seen;

    always #5 clk = ~clk;

    mesi_isc_broad_cntl dut (
        .clk                      (clk),
        .rst                      (rst),
        .broad_fifo_status_empty_i(broad_fifo_status_empty_i),
        .broad_addr_i             (broad_addr_i),
        .broad_type_i             (broad_type_i),
        .broad_cpu_id_i           (broad_cpu_id_i),
        .broad_id_i               (broad_id_i),
        .broad_fifo_rd_o          (broad_fifo_rd_o),
        .cbus_ack_array_i         (cbus_ack_array_i),
        .cbus_cmd_array_o         (cbus_cmd_array_o),
        .cbus_addr_o              (cbus_addr_o),
        .broad_busy_o             (broad_busy_o),
        .broad_id_active_o        (broad_id_active_o)
    );

    function automatic logic [11:0] cm(input logic [2:0] c3, input logic [2:0] c2,
                                       input logic [2:0] c1, input logic [2:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic refresh();
        broad_fifo_status_empty_i = (fq.size() == 0);
        if (fq.size() > 0) begin
            broad_addr_i   = fq[0].addr;
            broad_type_i   = fq[0].typ;
            broad_cpu_id_i = fq[0].cpu;
            broad_id_i     = fq[0].id;
        end
    endtask

    task automatic push(input logic [1:0] typ, input logic [1:0] cpu,
                        input logic [31:0] addr, input logic [6:0] id);
        fent_t e;
        e.addr = addr;
        e.typ  = typ;
        e.cpu  = cpu;
        e.id   = id;
        fq.push_back(e);
        refresh();
    endtask

    // One clock: pop the FIFO model if the DUT asked, clear ack pulses.
    task automatic tick();
        @(negedge clk);
        rd_seen = broad_fifo_rd_o;
        @(posedge clk);
        #1;
        cyc++;
        cbus_ack_array_i = 4'b0000;
        if (rd_seen && fq.size() > 0) void'(fq.pop_front());
        refresh();
    endtask

    task automatic expect_ev(input int at, input logic rd, input logic [11:0] cmd,
                             input logic busy, input logic [31:0] addr,
                             input logic [6:0] id);
        ev_t e;
        e.cyc  = at;
        e.rd   = rd;
        e.cmd  = cmd;
        e.busy = busy;
        e.addr = addr;
        e.id   = id;
        exq.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Monitor: any pop or change on the cbus/status outputs is an event.
    logic [11:0] p_cmd  = '0;
    logic        p_busy = 1'b0;
    logic [31:0] p_addr = '0;
    logic [6:0]  p_id   = '0;

    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if (broad_fifo_rd_o || cbus_cmd_array_o !== p_cmd ||
                broad_busy_o !== p_busy || cbus_addr_o !== p_addr ||
                broad_id_active_o !== p_id) begin
                checks++;
                if (exq.size() == 0) begin
                    $display("FAIL unexpected_event: cyc=%0d rd=%0b cmd=%03h busy=%0b addr=%08h id=%02h, required no event",
                             cyc, broad_fifo_rd_o, cbus_cmd_array_o,
                             broad_busy_o, cbus_addr_o, broad_id_active_o);
                end else begin
                    e = exq.pop_front();
                    if (e.cyc == cyc && e.rd === broad_fifo_rd_o &&
                        e.cmd === cbus_cmd_array_o && e.busy === broad_busy_o &&
                        e.addr === cbus_addr_o && e.id === broad_id_active_o)
                        passes++;
                    else
                        $display("FAIL event: got cyc=%0d rd=%0b cmd=%03h busy=%0b addr=%08h id=%02h, required cyc=%0d rd=%0b cmd=%03h busy=%0b addr=%08h id=%02h",
                                 cyc, broad_fifo_rd_o, cbus_cmd_array_o,
                                 broad_busy_o, cbus_addr_o, broad_id_active_o,
                                 e.cyc, e.rd, e.cmd, e.busy, e.addr, e.id);
                end
            end
            p_cmd  = cbus_cmd_array_o;
            p_busy = broad_busy_o;
            p_addr = cbus_addr_o;
            p_id   = broad_id_active_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick();
        tick();
        chk("rst_cmd",  32'(cbus_cmd_array_o), 32'h0);
        chk("rst_addr", cbus_addr_o, 32'h0);
        chk("rst_id",   32'(broad_id_active_o), 32'h0);
        chk("rst_busy", 32'(broad_busy_o), 32'h0);
        chk("rst_rd",   32'(broad_fifo_rd_o), 32'h0);
        rst = 1'b1;
        mon_en = 1'b1;
        tick();

        // WR from CPU2, immediate acks; then spurious acks in IDLE.
        n = cyc;
        push(T_WR, 2'd2, 32'h1000, 7'h11);
        expect_ev(n,   1'b1, 12'h0, 1'b0, 32'h0, 7'h0);
        expect_ev(n+1, 1'b0, cm(WS, NOP, WS, WS), 1'b1, 32'h1000, 7'h11);
        expect_ev(n+2, 1'b0, cm(NOP, EW, NOP, NOP), 1'b1, 32'h1000, 7'h11);
        expect_ev(n+3, 1'b0, 12'h0, 1'b0, 32'h1000, 7'h11);
        tick(); cbus_ack_array_i = 4'b1011;
        tick(); cbus_ack_array_i = 4'b0100;
        tick(); cbus_ack_array_i = 4'b1111;
        tick();
        tick();

        // RD from CPU0 with staggered acks and spurious ones mixed in.
        n = cyc;
        push(T_RD, 2'd0, 32'h2000, 7'h22);
        expect_ev(n,   1'b1, 12'h0, 1'b0, 32'h1000, 7'h11);
        expect_ev(n+1, 1'b0, cm(RS, RS, RS, NOP), 1'b1, 32'h2000, 7'h22);
        expect_ev(n+3, 1'b0, cm(RS, RS, NOP, NOP), 1'b1, 32'h2000, 7'h22);
        expect_ev(n+4, 1'b0, cm(NOP, RS, NOP, NOP), 1'b1, 32'h2000, 7'h22);
        expect_ev(n+6, 1'b0, cm(NOP, NOP, NOP, ER), 1'b1, 32'h2000, 7'h22);
        expect_ev(n+8, 1'b0, 12'h0, 1'b0, 32'h2000, 7'h22);
        tick();
        tick(); cbus_ack_array_i = 4'b0010;
        tick(); cbus_ack_array_i = 4'b1000;
        tick(); cbus_ack_array_i = 4'b0011;
        tick(); cbus_ack_array_i = 4'b0100;
        tick(); cbus_ack_array_i = 4'b1110;
        tick(); cbus_ack_array_i = 4'b0001;
        tick();
        tick();

        // Two breqs queued back to back.
        n = cyc;
        push(T_WR, 2'd3, 32'h3000, 7'h33);
        push(T_RD, 2'd1, 32'h4000, 7'h44);
        expect_ev(n,   1'b1, 12'h0, 1'b0, 32'h2000, 7'h22);
        expect_ev(n+1, 1'b0, cm(NOP, WS, WS, WS), 1'b1, 32'h3000, 7'h33);
        expect_ev(n+2, 1'b0, cm(EW, NOP, NOP, NOP), 1'b1, 32'h3000, 7'h33);
        expect_ev(n+3, 1'b1, 12'h0, 1'b0, 32'h3000, 7'h33);
        expect_ev(n+4, 1'b0, cm(RS, RS, NOP, RS), 1'b1, 32'h4000, 7'h44);
        expect_ev(n+5, 1'b0, cm(NOP, NOP, ER, NOP), 1'b1, 32'h4000, 7'h44);
        expect_ev(n+6, 1'b0, 12'h0, 1'b0, 32'h4000, 7'h44);
        tick(); cbus_ack_array_i = 4'b0111;
        tick(); cbus_ack_array_i = 4'b1000;
        tick();
        tick(); cbus_ack_array_i = 4'b1101;
        tick(); cbus_ack_array_i = 4'b0010;
        tick();
        tick();

        // NOP-type entry is popped and dropped.
        n = cyc;
        push(T_NOP, 2'd1, 32'h7000, 7'h77);
        expect_ev(n,   1'b1, 12'h0, 1'b0, 32'h4000, 7'h44);
        expect_ev(n+1, 1'b0, 12'h0, 1'b0, 32'h7000, 7'h77);
        tick();
        tick();

        // Reset while the originator is enabled, then resume.
        n = cyc;
        push(T_WR, 2'd1, 32'h5000, 7'h55);
        expect_ev(n,   1'b1, 12'h0, 1'b0, 32'h7000, 7'h77);
        expect_ev(n+1, 1'b0, cm(WS, WS, NOP, WS), 1'b1, 32'h5000, 7'h55);
        expect_ev(n+2, 1'b0, 12'h0, 1'b0, 32'h0, 7'h0);
        tick(); cbus_ack_array_i = 4'b1101;
        tick();
        rst = 1'b0;
        #1;
        chk("async_rst_busy", 32'(broad_busy_o), 32'h0);
        chk("async_rst_cmd",  32'(cbus_cmd_array_o), 32'h0);
        tick();
        rst = 1'b1;
        push(T_RD, 2'd3, 32'h6000, 7'h66);
        expect_ev(n+3, 1'b1, 12'h0, 1'b0, 32'h0, 7'h0);
        expect_ev(n+4, 1'b0, cm(NOP, RS, RS, RS), 1'b1, 32'h6000, 7'h66);
        expect_ev(n+5, 1'b0, cm(ER, NOP, NOP, NOP), 1'b1, 32'h6000, 7'h66);
        expect_ev(n+6, 1'b0, 12'h0, 1'b0, 32'h6000, 7'h66);
        tick(); cbus_ack_array_i = 4'b0111;
        tick(); cbus_ack_array_i = 4'b1000;
        tick();
        tick();
        tick();

        chk("scoreboard_drained", 32'(exq.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
